// File: rtl/uart_tx_engine.sv
// uart_tx_engine: buffered UART transmitter with FIFO, runtime frame format, break and flush
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          uart_clk,
  input  logic                          uart_rst,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_en,
  output logic                          wr_full,
  output logic                          wr_overflow,
  input  logic                          fifo_flush,
  input  logic [3:0]                    cfg_data_len,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  input  logic                          cfg_break,
  input  logic                          baud_tick,
  output logic                          tx_serial,
  output logic                          tx_active,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          tx_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, BREAK = 3'd5;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [2:0] state;
  logic [DATA_WIDTH-1:0] shreg, head, mask;
  logic [3:0] len_c, len_q, bit_cnt;
  logic par_en_q, par_bit, stop2_q, stop_more;
  logic frame_end, pop, push;
  assign wr_full = count == LW'(FIFO_DEPTH);
  assign tx_empty = count == '0;
  assign tx_level = count;
  assign tx_active = state != IDLE;
  assign head = mem[rd_ptr];
  assign len_c = cfg_data_len < 4'd5 ? 4'd5 : cfg_data_len > 4'(DATA_WIDTH) ? 4'(DATA_WIDTH) : cfg_data_len;
  assign mask = DATA_WIDTH'((32'd1 << len_c) - 32'd1);
  assign frame_end = baud_tick && state == STOP && !stop_more;
  assign pop = (frame_end || (baud_tick && state == IDLE)) && !cfg_break && !tx_empty;
  assign push = wr_en && !wr_full && !fifo_flush;
  always_ff @(posedge uart_clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge uart_clk) begin
    wr_overflow <= !uart_rst && wr_en && wr_full && !fifo_flush;
    if (uart_rst || fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + LW'(push) - LW'(pop);
    end
  end
  // Frame format is captured at pop so config changes never corrupt a frame on the wire
  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      state <= IDLE;
      tx_serial <= 1'b1;
      tx_done <= 1'b0;
      shreg <= '0;
      len_q <= 4'd5;
      bit_cnt <= '0;
      par_en_q <= 1'b0;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
      stop_more <= 1'b0;
    end else begin
      tx_done <= frame_end;
      if (pop) begin
        shreg <= head & mask;
        len_q <= len_c;
        par_en_q <= cfg_parity_en;
        par_bit <= ^(head & mask) ^ cfg_parity_odd;
        stop2_q <= cfg_stop2;
      end
      if (baud_tick)
        case (state)
          IDLE, STOP:
            if (state == STOP && stop_more) begin
              stop_more <= 1'b0;
              tx_serial <= 1'b1;
            end else begin
              state <= cfg_break ? BREAK : pop ? START : IDLE;
              tx_serial <= !(cfg_break || pop);
            end
          START: begin
            state <= DATA;
            tx_serial <= shreg[0];
            shreg <= shreg >> 1;
            bit_cnt <= 4'd1;
          end
          DATA:
            if (bit_cnt == len_q) begin
              state <= par_en_q ? PARITY : STOP;
              tx_serial <= par_en_q ? par_bit : 1'b1;
              stop_more <= stop2_q;
            end else begin
              tx_serial <= shreg[0];
              shreg <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          PARITY: begin
            state <= STOP;
            tx_serial <= 1'b1;
            stop_more <= stop2_q;
          end
          BREAK:
            if (!cfg_break) begin
              state <= IDLE;
              tx_serial <= 1'b1;
            end
          default: begin
            state <= IDLE;
            tx_serial <= 1'b1;
          end
        endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: vector table, directed corner cases and random traffic against a bit-list frame model
module tb_uart_tx_engine;
  logic uart_clk = 1'b0, uart_rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic wr_en = 1'b0, fifo_flush = 1'b0, baud_tick = 1'b0;
  logic cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0, cfg_stop2 = 1'b0, cfg_break = 1'b0;
  logic [3:0] cfg_data_len = 4'd8;
  logic wr_full, wr_overflow, tx_serial, tx_active, tx_empty, tx_done;
  logic [4:0] tx_level;
  int total = 0, passed = 0;
  logic [7:0] q[$];
  logic fb[$];
  logic m_line = 1'b1, m_frame = 1'b0, m_brk = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] len;
    logic pe, po, s2;
    int n;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[6];

  always #5 uart_clk = ~uart_clk;

  uart_tx_engine #(.FIFO_DEPTH(16), .DATA_WIDTH(8)) dut (
    .uart_clk(uart_clk), .uart_rst(uart_rst), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(wr_full), .wr_overflow(wr_overflow), .fifo_flush(fifo_flush),
    .cfg_data_len(cfg_data_len), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2(cfg_stop2), .cfg_break(cfg_break), .baud_tick(baud_tick), .tx_serial(tx_serial),
    .tx_active(tx_active), .tx_empty(tx_empty), .tx_level(tx_level), .tx_done(tx_done)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  function automatic void model_reset();
    q = {};
    fb = {};
    m_line = 1'b1;
    m_frame = 1'b0;
    m_brk = 1'b0;
    m_done = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // Remaining bits of a frame after its start bit, from the current config
  function automatic void build(input logic [7:0] w);
    int len = cfg_data_len < 5 ? 5 : cfg_data_len > 8 ? 8 : int'(cfg_data_len);
    logic p = cfg_parity_odd;
    fb = {};
    for (int i = 0; i < len; i++) begin
      fb.push_back(w[i]);
      p ^= w[i];
    end
    if (cfg_parity_en) fb.push_back(p);
    fb.push_back(1'b1);
    if (cfg_stop2) fb.push_back(1'b1);
  endfunction

  function automatic void model_edge();
    int sz = q.size();
    m_done = 1'b0;
    m_ovf = 1'b0;
    if (baud_tick) begin
      if (m_brk) begin
        if (!cfg_break) begin
          m_brk = 1'b0;
          m_line = 1'b1;
        end
      end else if (fb.size() > 0) m_line = fb.pop_front();
      else begin
        if (m_frame) begin
          m_done = 1'b1;
          m_frame = 1'b0;
        end
        if (cfg_break) begin
          m_brk = 1'b1;
          m_line = 1'b0;
        end else if (q.size() > 0) begin
          build(q.pop_front());
          m_line = 1'b0;
          m_frame = 1'b1;
        end else m_line = 1'b1;
      end
    end
    if (fifo_flush) q = {};
    else if (wr_en) begin
      if (sz == 16) m_ovf = 1'b1;
      else q.push_back(wr_data);
    end
  endfunction

  task automatic step(input logic tk, input logic we, input logic [7:0] wd, input logic fl);
    baud_tick = tk;
    wr_en = we;
    wr_data = wd;
    fifo_flush = fl;
    model_edge();
    @(posedge uart_clk);
    #1;
    baud_tick = 1'b0;
    wr_en = 1'b0;
    fifo_flush = 1'b0;
    chk("line", tx_serial, m_line);
    chk("done", tx_done, m_done);
    chk("level", tx_level, q.size());
    chk("empty", tx_empty, q.size() == 0);
    chk("full", wr_full, q.size() == 16);
    chk("ovf", wr_overflow, m_ovf);
    chk("active", tx_active, m_frame || m_brk);
  endtask

  task automatic set_cfg(input logic [3:0] l, input logic pe, input logic po, input logic s2);
    cfg_data_len = l;
    cfg_parity_en = pe;
    cfg_parity_odd = po;
    cfg_stop2 = s2;
  endtask

  initial begin
    int dn, cnt, found;
    logic [15:0] got;
    tbl[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 10, 16'b0101001011};
    tbl[1] = '{8'h35, 4'd7,  1'b1, 1'b0, 1'b1, 11, 16'b01010110011};
    tbl[2] = '{8'h35, 4'd7,  1'b1, 1'b1, 1'b1, 11, 16'b01010110111};
    tbl[3] = '{8'hFF, 4'd2,  1'b1, 1'b0, 1'b0, 8,  16'b01111111};
    tbl[4] = '{8'h81, 4'd15, 1'b1, 1'b1, 1'b0, 11, 16'b01000000111};
    tbl[5] = '{8'hC6, 4'd6,  1'b0, 1'b0, 1'b1, 9,  16'b001100011};
    repeat (3) @(posedge uart_clk);
    #1;
    chk("rst_line", tx_serial, 1);
    chk("rst_empty", tx_empty, 1);
    chk("rst_level", tx_level, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_active", tx_active, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ovf", wr_overflow, 0);
    uart_rst = 1'b0;
    model_reset();
    dn = 0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      dn += int'(tx_done);
      cnt += int'(tx_serial);
    end
    chk("idle_done", dn, 0);
    chk("idle_line", cnt, 100);
    for (int k = 0; k < 6; k++) begin
      set_cfg(tbl[k].len, tbl[k].pe, tbl[k].po, tbl[k].s2);
      step(1'b0, 1'b1, tbl[k].d, 1'b0);
      got = '0;
      dn = 0;
      for (int i = 0; i < tbl[k].n; i++) begin
        step(1'b1, 1'b0, 8'h00, 1'b0);
        got = {got[14:0], tx_serial};
        dn += int'(tx_done);
      end
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("vec_line", got, tbl[k].exp);
      chk("vec_done_early", dn, 0);
      chk("vec_done", tx_done, 1);
    end
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 8'(i * 13 + 7), 1'b0);
      cnt += int'(wr_overflow);
    end
    chk("fill_level", tx_level, 16);
    chk("fill_full", wr_full, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    cnt += int'(wr_overflow);
    chk("fill_ovf_pulses", cnt, 1);
    dn = 0;
    for (int i = 0; i < 161; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      dn += int'(tx_done);
    end
    chk("burst_done", dn, 16);
    chk("burst_idle", tx_active, 0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0);
    cfg_break = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      found = int'(tx_done);
    end
    chk("brk_frame_done", found, 1);
    chk("brk_line", tx_serial, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      cnt += int'(!tx_serial);
    end
    chk("brk_hold", cnt, 5);
    cfg_break = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("brk_release", tx_serial, 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("brk_resume", tx_serial, 0);
    repeat (12) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b1);
    chk("flush_level", tx_level, 0);
    chk("flush_ovf", wr_overflow, 0);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      dn += int'(tx_done);
    end
    chk("flush_frames", dn, 1);
    chk("flush_idle", tx_active, 0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0)
        set_cfg(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
      if (cfg_break ? $urandom_range(0, 19) == 0 : $urandom_range(0, 299) == 0) cfg_break = !cfg_break;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 199) == 0);
    end
    cfg_break = 1'b0;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
    uart_rst = 1'b1;
    @(posedge uart_clk);
    #1;
    uart_rst = 1'b0;
    model_reset();
    chk("midrst_line", tx_serial, 1);
    chk("midrst_level", tx_level, 0);
    chk("midrst_active", tx_active, 0);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
